gf_pow_mac: RTL

GF_POW_MAC -- requirements
Module: gf_pow_mac

---
 rtl/gf_pkg.sv | 18 +
 rtl/gf_pow_add.sv | 28 ++
 rtl/gf_pow_mac.sv | 105 ++++++++++
 3 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) widths, power-code/symbol types and the MAC state encoding.
package gf_pkg;
    localparam int GF_W     = 8;
    localparam int GF_ORDER = 255;

    typedef logic [GF_W-1:0] pow_t;
    typedef logic [GF_W-1:0] sym_t;

    // Power code 0 stands for the zero element, k>0 for alpha^(k-1).
    localparam pow_t POW_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_FLUSH,
        ST_HOLD
    } state_e;
endpackage

// File: rtl/gf_pow_add.sv
// Multiplies two power-coded field elements by adding exponents mod the group order.
module gf_pow_add #(
    parameter int GF_W     = gf_pkg::GF_W,
    parameter int GF_ORDER = gf_pkg::GF_ORDER
) (
    input  logic [GF_W-1:0] a_pow_i,
    input  logic [GF_W-1:0] b_pow_i,
    output logic [GF_W-1:0] rom_addr_o
);
    import gf_pkg::*;

    logic [GF_W:0] sum_raw;
    logic [GF_W:0] sum_red;

    always_comb begin
        // Both codes carry a +1 offset, so strip two before the single reduction.
        sum_raw = {1'b0, a_pow_i} + {1'b0, b_pow_i} - (GF_W+1)'(2);
        sum_red = sum_raw;
        if (sum_raw >= (GF_W+1)'(GF_ORDER)) begin
            sum_red = sum_raw - (GF_W+1)'(GF_ORDER);
        end
        if (a_pow_i == GF_W'(POW_ZERO) || b_pow_i == GF_W'(POW_ZERO)) begin
            rom_addr_o = '0;
        end else begin
            rom_addr_o = sum_red[GF_W-1:0] + GF_W'(1);
        end
    end
endmodule

// File: rtl/gf_pow_mac.sv
// Streaming GF dot-product: each term pair is multiplied via an external antilog ROM
// and XOR-accumulated; the sum and term count are presented per vector.
module gf_pow_mac #(
    parameter int GF_W     = gf_pkg::GF_W,
    parameter int GF_ORDER = gf_pkg::GF_ORDER
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [GF_W-1:0] a_pow,
    input  logic [GF_W-1:0] b_pow,
    input  logic            in_last,
    output logic            rom_re,
    output logic [GF_W-1:0] rom_addr,
    input  logic [GF_W-1:0] rom_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [GF_W-1:0] out_sum,
    output logic [GF_W-1:0] out_terms
);
    import gf_pkg::*;

    state_e          state_q;
    logic [GF_W-1:0] acc_q, acc_d;
    logic [GF_W-1:0] cnt_q, cnt_d;
    logic            rd_q;
    logic            last_q;
    logic            out_valid_q;
    logic [GF_W-1:0] out_sum_q;
    logic [GF_W-1:0] out_terms_q;
    logic            accept;

    gf_pow_add #(
        .GF_W     (GF_W),
        .GF_ORDER (GF_ORDER)
    ) u_pow_add (
        .a_pow_i    (a_pow),
        .b_pow_i    (b_pow),
        .rom_addr_o (rom_addr)
    );

    // FLUSH means the last term's ROM read is in flight; no new term may enter.
    assign in_ready = rst_n & (state_q != ST_FLUSH) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign rom_re   = accept;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (rd_q) begin
            acc_d = acc_q ^ rom_data;
        end
        if (accept && cnt_q != {GF_W{1'b1}}) begin
            cnt_d = cnt_q + GF_W'(1);
        end
        if (last_q) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_terms_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            rd_q   <= accept;
            last_q <= accept & in_last;

            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (last_q) begin
                out_sum_q   <= acc_q ^ rom_data;
                out_terms_q <= cnt_q;
                out_valid_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (accept) state_q <= in_last ? ST_FLUSH : ST_ACC;
                end
                ST_FLUSH: state_q <= ST_HOLD;
                ST_HOLD: begin
                    if (accept)         state_q <= in_last ? ST_FLUSH : ST_ACC;
                    else if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_terms = out_terms_q;
endmodule
